// File: rtl/map_timer_if.sv
// Register bus for the map_timer: 2-bit register select, 16-bit write data,
// write strobe and combinational read data.
interface map_timer_if;
  logic [1:0]  i_memAddr;
  logic [15:0] i_memDataIn;
  logic        i_memWrEn;
  logic [15:0] o_memDataOut;

  modport master (
    output i_memAddr,
    output i_memDataIn,
    output i_memWrEn,
    input  o_memDataOut
  );

  modport slave (
    input  i_memAddr,
    input  i_memDataIn,
    input  i_memWrEn,
    output o_memDataOut
  );
endinterface

// File: rtl/map_timer.sv
// map_timer: memory-mapped 16-bit up-counter with a 2^PRE prescaler.
// COUNT wraps to 0 when a tick finds COUNT==MAX. That wrap raises a
// one-cycle registered overflow pulse on o_intOVF.
module map_timer (
  input  logic        i_clk,
  input  logic        i_rstn,
  map_timer_if.slave  bus,
  output logic        o_intOVF
);

  localparam logic [1:0] ADDR_CTRL  = 2'b00;
  localparam logic [1:0] ADDR_MAX   = 2'b01;
  localparam logic [1:0] ADDR_COUNT = 2'b10;

  logic        en_r;
  logic [2:0]  pre_r;
  logic [15:0] max_r;
  logic [15:0] count_r;
  logic [6:0]  ps_r;
  logic        ovf_r;

  logic        ctrl_wr_s;
  logic        max_wr_s;
  logic        count_wr_s;
  logic        tick_s;
  logic        at_max_s;
  logic        ovf_event_s;
  logic [6:0]  ps_next_s;
  logic [15:0] count_next_s;
  logic [15:0] rdata_s;

  // Terminal prescaler value for a given PRE setting: 2^PRE - 1.
  function automatic logic [6:0] pre_mask(input logic [2:0] pre);
    logic [6:0] m;
    case (pre)
      3'd0:    m = 7'h00;
      3'd1:    m = 7'h01;
      3'd2:    m = 7'h03;
      3'd3:    m = 7'h07;
      3'd4:    m = 7'h0F;
      3'd5:    m = 7'h1F;
      3'd6:    m = 7'h3F;
      3'd7:    m = 7'h7F;
      default: m = 7'h7F;
    endcase
    return m;
  endfunction

  // Decode write strobes per register; address 11 decodes to nothing.
  always_comb begin
    ctrl_wr_s  = 1'b0;
    max_wr_s   = 1'b0;
    count_wr_s = 1'b0;
    if (bus.i_memWrEn) begin
      case (bus.i_memAddr)
        ADDR_CTRL:  ctrl_wr_s  = 1'b1;
        ADDR_MAX:   max_wr_s   = 1'b1;
        ADDR_COUNT: count_wr_s = 1'b1;
        default: begin
          ctrl_wr_s  = 1'b0;
          max_wr_s   = 1'b0;
          count_wr_s = 1'b0;
        end
      endcase
    end else begin
      ctrl_wr_s  = 1'b0;
      max_wr_s   = 1'b0;
      count_wr_s = 1'b0;
    end
  end

  // Tick and counter next-state. Tick uses the current (pre-write) CTRL,
  // the compare uses the current MAX, and a COUNT write wins over a tick.
  always_comb begin
    tick_s       = en_r && (ps_r == pre_mask(pre_r));
    at_max_s     = (count_r == max_r);
    ovf_event_s  = 1'b0;
    ps_next_s    = ps_r;
    count_next_s = count_r;

    if (ctrl_wr_s) begin
      ps_next_s = 7'd0;
    end else if (tick_s) begin
      ps_next_s = 7'd0;
    end else if (en_r) begin
      ps_next_s = ps_r + 7'd1;
    end else begin
      ps_next_s = ps_r;
    end

    if (count_wr_s) begin
      count_next_s = bus.i_memDataIn;
      ovf_event_s  = 1'b0;
    end else if (tick_s && at_max_s) begin
      count_next_s = 16'd0;
      ovf_event_s  = 1'b1;
    end else if (tick_s) begin
      count_next_s = count_r + 16'd1;
      ovf_event_s  = 1'b0;
    end else begin
      count_next_s = count_r;
      ovf_event_s  = 1'b0;
    end
  end

  // Register state; synchronous active-low reset overrides writes and ticks.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      en_r    <= 1'b0;
      pre_r   <= 3'd0;
      max_r   <= 16'd0;
      count_r <= 16'd0;
      ps_r    <= 7'd0;
      ovf_r   <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        en_r  <= bus.i_memDataIn[0];
        pre_r <= bus.i_memDataIn[3:1];
      end
      if (max_wr_s) begin
        max_r <= bus.i_memDataIn;
      end
      count_r <= count_next_s;
      ps_r    <= ps_next_s;
      ovf_r   <= ovf_event_s;
    end
  end

  // Zero-latency, side-effect-free register read mux.
  always_comb begin
    rdata_s = 16'h0000;
    case (bus.i_memAddr)
      ADDR_CTRL:  rdata_s = {12'h000, pre_r, en_r};
      ADDR_MAX:   rdata_s = max_r;
      ADDR_COUNT: rdata_s = count_r;
      default:    rdata_s = 16'h0000;
    endcase
  end

  assign bus.o_memDataOut = rdata_s;
  assign o_intOVF         = ovf_r;

endmodule

// File: tb/tb_map_timer.sv
// Directed self-checking bench for map_timer. Inputs change just after
// the falling edge and outputs are sampled there, away from the rising edge.
module tb_map_timer;

  logic i_clk;
  logic i_rstn;
  logic o_intOVF;
  int   n_cmp;
  int   n_fail;

  map_timer_if bus ();

  map_timer dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .bus      (bus.slave),
    .o_intOVF (o_intOVF)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Drive a write that lands on the next rising edge; return at the following negedge.
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.i_memAddr   = a;
    bus.i_memDataIn = d;
    bus.i_memWrEn   = 1'b1;
    @(negedge i_clk);
    bus.i_memWrEn   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
    bus.i_memAddr = a;
    #1;
    chk(tag, bus.o_memDataOut, exp);
  endtask

  task automatic ovf(input logic exp, input string tag);
    chk(tag, {15'd0, o_intOVF}, {15'd0, exp});
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    i_rstn = 1'b0;
    bus.i_memAddr   = 2'b00;
    bus.i_memDataIn = 16'h0000;
    bus.i_memWrEn   = 1'b0;
    step(2);
    i_rstn = 1'b1;
    step(1);

    // Reset state
    ovf(1'b0, "rst_ovf");
    rd(2'b00, 16'h0000, "rst_ctrl");
    rd(2'b01, 16'h0000, "rst_max");
    step(1);
    rd(2'b10, 16'h0000, "rst_count");
    rd(2'b11, 16'h0000, "rst_rsvd");
    step(1);

    // Basic wrap, MAX=3, PRE=0
    wr(2'b01, 16'd3);
    wr(2'b00, 16'h0001);
    rd(2'b10, 16'd0, "wrap_c0");
    step(1); rd(2'b10, 16'd1, "wrap_c1");
    step(1); rd(2'b10, 16'd2, "wrap_c2");
    step(1); rd(2'b10, 16'd3, "wrap_c3"); ovf(1'b0, "wrap_noovf3");
    step(1); rd(2'b10, 16'd0, "wrap_c0b"); ovf(1'b1, "wrap_ovf1");
    step(1); rd(2'b10, 16'd1, "wrap_c1b"); ovf(1'b0, "wrap_ovf_off");
    step(2); rd(2'b10, 16'd3, "wrap_c3b"); ovf(1'b0, "wrap_noovf3b");
    // Disable on the wrap cycle: the wrap still happens and the pulse still fires
    wr(2'b00, 16'h0000);
    rd(2'b10, 16'd0, "dis_c0"); ovf(1'b1, "dis_ovf2");
    step(1); rd(2'b10, 16'd0, "dis_hold1"); ovf(1'b0, "dis_ovf_off");
    step(2); rd(2'b10, 16'd0, "dis_hold2");

    // Prescale PRE=2, MAX=1
    wr(2'b10, 16'd0);
    wr(2'b01, 16'd1);
    wr(2'b00, 16'h0005);
    rd(2'b00, 16'h0005, "ps_ctrl");
    step(3); rd(2'b10, 16'd0, "ps_c0_3cyc");
    step(1); rd(2'b10, 16'd1, "ps_c1_4cyc"); ovf(1'b0, "ps_noovf4");
    step(3); ovf(1'b0, "ps_noovf7");
    step(1); rd(2'b10, 16'd0, "ps_wrap8"); ovf(1'b1, "ps_ovf8");
    step(1); ovf(1'b0, "ps_ovf_off");
    step(7); ovf(1'b1, "ps_ovf16");

    // Write-vs-tick collision, PRE=0 MAX=5 COUNT=5
    wr(2'b00, 16'h0000);
    wr(2'b01, 16'd5);
    wr(2'b10, 16'd5);
    step(1);
    ovf(1'b0, "col_pre");
    wr(2'b00, 16'h0001);
    wr(2'b10, 16'd2);
    rd(2'b10, 16'd2, "col_c2"); ovf(1'b0, "col_noovf");
    step(1); rd(2'b10, 16'd3, "col_c3"); ovf(1'b0, "col_noovf2");

    // COUNT above MAX rolls through 0xFFFF without overflow
    wr(2'b00, 16'h0000);
    wr(2'b01, 16'd3);
    wr(2'b10, 16'hFFFE);
    step(1);
    wr(2'b00, 16'h0001);
    rd(2'b10, 16'hFFFE, "roll_fffe");
    step(1); rd(2'b10, 16'hFFFF, "roll_ffff"); ovf(1'b0, "roll_noovf1");
    step(1); rd(2'b10, 16'h0000, "roll_0000"); ovf(1'b0, "roll_noovf2");
    step(1); rd(2'b10, 16'h0001, "roll_0001"); ovf(1'b0, "roll_noovf3");

    // MAX=0: every tick overflows
    wr(2'b00, 16'h0000);
    wr(2'b10, 16'd0);
    wr(2'b01, 16'd0);
    step(1);
    wr(2'b00, 16'h0001);
    ovf(1'b0, "max0_first");
    step(1); ovf(1'b1, "max0_ovf1"); rd(2'b10, 16'd0, "max0_c");
    step(1); ovf(1'b1, "max0_ovf2");
    step(1); ovf(1'b1, "max0_ovf3"); rd(2'b10, 16'd0, "max0_c2");

    // Mid-operation reset coincident with a CTRL write
    wr(2'b00, 16'h0000);
    wr(2'b10, 16'd0);
    wr(2'b01, 16'h00FF);
    wr(2'b00, 16'h0001);
    step(5);
    rd(2'b10, 16'd5, "mid_c5");
    i_rstn = 1'b0;
    wr(2'b00, 16'h0001);
    i_rstn = 1'b1;
    ovf(1'b0, "mrst_ovf");
    rd(2'b00, 16'h0000, "mrst_ctrl");
    rd(2'b01, 16'h0000, "mrst_max");
    rd(2'b10, 16'h0000, "mrst_count");
    step(3);
    rd(2'b10, 16'h0000, "mrst_nocount");
    ovf(1'b0, "mrst_ovf2");

    // Register map with all-ones writes
    wr(2'b01, 16'hFFFF);
    wr(2'b10, 16'hFFFF);
    wr(2'b11, 16'hFFFF);
    wr(2'b00, 16'hFFFF);
    rd(2'b00, 16'h000F, "map_ctrl");
    rd(2'b01, 16'hFFFF, "map_max");
    rd(2'b10, 16'hFFFF, "map_count");
    step(1);
    rd(2'b11, 16'h0000, "map_rsvd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
